// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline control encodings.
// Holds the hazard FSM state codes, the forwarding-mux select codes and the
// bundle of pipeline control signals produced by the hazard controller.
package mips_pkg;
   localparam logic [1:0] RUN        = 2'b00;
   localparam logic [1:0] LOAD_STALL = 2'b01;
   localparam logic [1:0] MEM_WAIT   = 2'b10;
   localparam logic [1:0] FLUSH      = 2'b11;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic pcWrite;
      logic ifidWrite;
      logic ifidFlush;
      logic idexBubble;
      logic idexHold;
      logic exmemHold;
   } ctrlBundle_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Ports: idRs/idRt/idUsesRt describe the ID instruction's sources, exRd/exMemRead
// the EX instruction; loadUse is high when ID needs a load result not yet loaded.
// r0 is never a real dependency, so it can never trigger a stall.
module hazard_detect
   import mips_pkg::*;
(
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   input  logic       idUsesRt,
   input  logic [4:0] exRd,
   input  logic       exMemRead,
   output logic       loadUse
);
   assign loadUse = exMemRead && exRd != 5'd0 && (exRd == idRs || (idUsesRt && exRd == idRt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline stall/flush/hold controller with memory-wait timeout.
// Inputs: clk, rst_n (sync active-low), ID sources (id_rs, id_rt, id_uses_rt),
// EX destination/load/branch (ex_rd, ex_mem_read, ex_branch_taken), MEM handshake
// (mem_req, mem_ready).
// Outputs: pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold
// (Mealy, valid in the detection cycle), hazard_state, sticky mem_timeout,
// stall_count/flush_count statistics.
// Macro HAZARD_STATS_EN enables the statistics counters; otherwise they read 0.
module pipeline_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             idex_hold,
   output logic             exmem_hold,
   output logic [1:0]       hazard_state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   logic [1:0] state, nextState, curState;
   logic [WAIT_W-1:0] waitCnt, waitNext;
   logic memWait, loadUse, luHit;
   ctrlBundle_t ctrl;

   // During reset the control outputs behave as if already in RUN.
   assign curState = rst_n ? state : RUN;
   assign memWait  = mem_req && !mem_ready;

   hazard_detect uDetect (
      .idRs      (id_rs),
      .idRt      (id_rt),
      .idUsesRt  (id_uses_rt),
      .exRd      (ex_rd),
      .exMemRead (ex_mem_read),
      .loadUse   (loadUse)
   );

   // The cycle right after a stall or flush holds a bubble in EX, so the
   // comparison there would be against stale data and is ignored.
   assign luHit = loadUse && (curState == RUN || curState == MEM_WAIT);

   always_comb begin
      ctrl      = '{pcWrite: 1'b1, ifidWrite: 1'b1, default: 1'b0};
      nextState = RUN;
      if (memWait) begin
         ctrl.pcWrite   = 1'b0;
         ctrl.ifidWrite = 1'b0;
         ctrl.idexHold  = 1'b1;
         ctrl.exmemHold = 1'b1;
         nextState      = MEM_WAIT;
      end else if (ex_branch_taken) begin
         ctrl.ifidFlush  = 1'b1;
         ctrl.idexBubble = 1'b1;
         nextState       = FLUSH;
      end else if (luHit) begin
         ctrl.pcWrite    = 1'b0;
         ctrl.ifidWrite  = 1'b0;
         ctrl.idexBubble = 1'b1;
         nextState       = LOAD_STALL;
      end
   end

   // Counts consecutive waiting cycles, including the one that detects the wait.
   assign waitNext = !memWait ? '0 : waitCnt == WAIT_MAX ? WAIT_MAX : waitCnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         waitCnt     <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= nextState;
         waitCnt     <= waitNext;
         mem_timeout <= mem_timeout || waitNext == WAIT_MAX;
      end
   end

   assign pc_write     = ctrl.pcWrite;
   assign ifid_write   = ctrl.ifidWrite;
   assign ifid_flush   = ctrl.ifidFlush;
   assign idex_bubble  = ctrl.idexBubble;
   assign idex_hold    = ctrl.idexHold;
   assign exmem_hold   = ctrl.exmemHold;
   assign hazard_state = state;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stallCnt, flushCnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (!ctrl.pcWrite && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
         if (ctrl.ifidFlush && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
      end
   end

   assign stall_count = stallCnt;
   assign flush_count = flushCnt;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
   localparam int T    = 4;
   localparam int CW   = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 0;
   logic rst_n;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
   logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;
   logic [1:0] hazard_state;
   logic mem_timeout;
   logic [CW-1:0] stall_count, flush_count;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .idex_hold(idex_hold),
      .exmem_hold(exmem_hold), .hazard_state(hazard_state), .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic pcW, ifW, flush, bubble, idH, exH;
      logic [1:0] st;
      logic to;
      logic [CW-1:0] sc, fc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   int mState = 0;
   int waitRun = 0;
   bit mTo = 0;
   int sc = 0, fc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit rn, input int rs, input int rt, input bit urt, input int rd,
                        input bit mr, input bit br, input bit rq, input bit rdy);
      exp_t e;
      bit mw, supp, lu;
      int nxt;
      rst_n = rn; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt; ex_rd = 5'(rd);
      ex_mem_read = mr; ex_branch_taken = br; mem_req = rq; mem_ready = rdy;
      mw   = rq && !rdy;
      supp = rn && (mState == 1 || mState == 3);
      lu   = !supp && mr && rd != 0 && (rd == rs || (urt && rd == rt));
      e.st = 2'(mState); e.to = mTo;
`ifdef HAZARD_STATS_EN
      e.sc = CW'(sc); e.fc = CW'(fc);
`else
      e.sc = '0; e.fc = '0;
`endif
      e.pcW = 1; e.ifW = 1; e.flush = 0; e.bubble = 0; e.idH = 0; e.exH = 0;
      if (mw) begin
         e.pcW = 0; e.ifW = 0; e.idH = 1; e.exH = 1; nxt = 2;
      end else if (br) begin
         e.flush = 1; e.bubble = 1; nxt = 3;
      end else if (lu) begin
         e.pcW = 0; e.ifW = 0; e.bubble = 1; nxt = 1;
      end else nxt = 0;
      sb.push_back(e);
      if (!rn) begin
         mState = 0; waitRun = 0; mTo = 0; sc = 0; fc = 0;
      end else begin
         mState = nxt;
         waitRun = mw ? (waitRun < T ? waitRun + 1 : T) : 0;
         if (waitRun == T) mTo = 1;
         if (!e.pcW && sc < CMAX) sc++;
         if (e.flush && fc < CMAX) fc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 1, 2, 0, 3, 0, 0, 0, 0);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_write", 32'(pc_write), 32'(e.pcW));
            chk("ifid_write", 32'(ifid_write), 32'(e.ifW));
            chk("ifid_flush", 32'(ifid_flush), 32'(e.flush));
            chk("idex_bubble", 32'(idex_bubble), 32'(e.bubble));
            chk("idex_hold", 32'(idex_hold), 32'(e.idH));
            chk("exmem_hold", 32'(exmem_hold), 32'(e.exH));
            chk("hazard_state", 32'(hazard_state), 32'(e.st));
            chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
            chk("stall_count", 32'(stall_count), 32'(e.sc));
            chk("flush_count", 32'(flush_count), 32'(e.fc));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rd = 0;
      ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on rs, then bubble cycle, then RUN
      drive(1, 5, 0, 0, 5, 1, 0, 0, 0);
      drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      // r0 exemption
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
      // load-use on rt, with and without rt being read
      drive(1, 1, 7, 1, 7, 1, 0, 0, 0);
      idle(1);
      drive(1, 1, 7, 0, 7, 1, 0, 0, 0);
      // branch together with load-use
      drive(1, 5, 0, 0, 5, 1, 1, 0, 0);
      idle(2);
      // three wait cycles then ready
      for (int i = 0; i < 3; i++) drive(1, 1, 2, 0, 3, 0, 0, 1, 0);
      drive(1, 1, 2, 0, 3, 0, 0, 1, 1);
      idle(1);
      // six wait cycles: timeout after the fourth, sticky afterwards
      for (int i = 0; i < 6; i++) drive(1, 1, 2, 0, 3, 0, 0, 1, 0);
      drive(1, 1, 2, 0, 3, 0, 0, 1, 1);
      idle(2);
      // reset in the middle of a wait
      for (int i = 0; i < 2; i++) drive(1, 1, 2, 0, 3, 0, 0, 1, 0);
      drive(0, 1, 2, 0, 3, 0, 0, 1, 0);
      idle(2);
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 49) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
